// File: rtl/space_invaders_pkg.sv
// Types and screen constants shared by the player, alien and bullet blocks.
package space_invaders_pkg;

   localparam int POS_W        = 10;
   localparam int SCREEN_X_MAX = 639;
   localparam int SCREEN_Y_MAX = 479;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLIGHT  = 2'd1,
      EXPLODE = 2'd2
   } bullet_state_t;

endpackage

// File: rtl/player_bullet_if.sv
// Player bullet bus: fire request and hit report in, position and status out.
interface player_bullet_if;
   import space_invaders_pkg::*;

   logic             shoot_bullet;
   logic [POS_W-1:0] player_X;
   logic             bullet_hit;
   logic [POS_W-1:0] bullet_X;
   logic [POS_W-1:0] bullet_Y;
   logic             bullet_active;
   logic             bullet_explode;
   logic             fire_ack;

   modport master (
      output shoot_bullet, player_X, bullet_hit,
      input  bullet_X, bullet_Y, bullet_active, bullet_explode, fire_ack
   );

   modport slave (
      input  shoot_bullet, player_X, bullet_hit,
      output bullet_X, bullet_Y, bullet_active, bullet_explode, fire_ack
   );

endinterface

// File: rtl/rising_edge_detect.sv
// One-flop rising edge detector; RESET_VAL=1 suppresses an edge for a level held through reset.
module rising_edge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic frame_clk,
   input  logic Reset_n,
   input  logic d,
   output logic rise
);

   logic d_prev;

   always_ff @(posedge frame_clk) begin
      if (!Reset_n) d_prev <= RESET_VAL;
      else          d_prev <= d;
   end

   assign rise = d & ~d_prev;

endmodule

// File: rtl/player_bullet.sv
// Player bullet controller: launches one bullet from the cannon, moves it up each
// frame, and ends it on a hit (with explosion hold) or at the top of the screen.
module player_bullet
   import space_invaders_pkg::*;
#(
   parameter int BULLET_Y_START  = 440,
   parameter int BULLET_Y_MIN    = 0,
   parameter int BULLET_STEP     = 4,
   parameter int EXPLODE_FRAMES  = 8,
   parameter int COOLDOWN_FRAMES = 16
) (
   input logic            frame_clk,
   input logic            Reset_n,
   player_bullet_if.slave bus
);

   localparam int CD_W = $clog2(COOLDOWN_FRAMES) + 1;
   localparam int EX_W = $clog2(EXPLODE_FRAMES) + 1;

   localparam logic [POS_W-1:0] Y_START = POS_W'(BULLET_Y_START);
   localparam logic [POS_W-1:0] Y_STEP  = POS_W'(BULLET_STEP);
   localparam logic [POS_W-1:0] Y_TOP   = POS_W'(BULLET_Y_MIN + BULLET_STEP);
   localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_FRAMES);
   localparam logic [EX_W-1:0]  EX_LOAD = EX_W'(EXPLODE_FRAMES - 1);

   bullet_state_t    state, next_state;
   logic [POS_W-1:0] bullet_x, next_x;
   logic [POS_W-1:0] bullet_y, next_y;
   logic [CD_W-1:0]  cooldown, next_cooldown;
   logic [EX_W-1:0]  explode_cnt, next_explode_cnt;
   logic             fire_ack, next_fire_ack;
   logic             fire_edge;

   rising_edge_detect #(
      .RESET_VAL (1'b1)
   ) u_fire_edge (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .d         (bus.shoot_bullet),
      .rise      (fire_edge)
   );

   always_comb begin
      next_state       = state;
      next_x           = bullet_x;
      next_y           = bullet_y;
      next_cooldown    = cooldown;
      next_explode_cnt = explode_cnt;
      next_fire_ack    = 1'b0;
      case (state)
         IDLE: begin
            // Requests during cooldown are dropped, never queued.
            if (cooldown != '0) begin
               next_cooldown = cooldown - CD_W'(1);
            end else if (fire_edge) begin
               next_state    = FLIGHT;
               next_x        = bus.player_X;
               next_y        = Y_START;
               next_fire_ack = 1'b1;
            end
         end
         FLIGHT: begin
            // Hit outranks the top exit; the top test precedes the subtract so Y never wraps.
            if (bus.bullet_hit) begin
               next_state       = EXPLODE;
               next_explode_cnt = EX_LOAD;
            end else if (bullet_y < Y_TOP) begin
               next_state    = IDLE;
               next_cooldown = CD_LOAD;
            end else begin
               next_y = bullet_y - Y_STEP;
            end
         end
         EXPLODE: begin
            if (explode_cnt == '0) begin
               next_state    = IDLE;
               next_cooldown = CD_LOAD;
            end else begin
               next_explode_cnt = explode_cnt - EX_W'(1);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (!Reset_n) begin
         state       <= IDLE;
         bullet_x    <= '0;
         bullet_y    <= '0;
         cooldown    <= '0;
         explode_cnt <= '0;
         fire_ack    <= 1'b0;
      end else begin
         state       <= next_state;
         bullet_x    <= next_x;
         bullet_y    <= next_y;
         cooldown    <= next_cooldown;
         explode_cnt <= next_explode_cnt;
         fire_ack    <= next_fire_ack;
      end
   end

   assign bus.bullet_X       = bullet_x;
   assign bus.bullet_Y       = bullet_y;
   assign bus.bullet_active  = (state == FLIGHT);
   assign bus.bullet_explode = (state == EXPLODE);
   assign bus.fire_ack       = fire_ack;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: launch, flight, exit, hit, cooldown, held request, reset.
module tb_player_bullet;
   import space_invaders_pkg::*;

   logic frame_clk = 1'b0;
   logic Reset_n   = 1'b0;
   int   total     = 0;
   int   bad       = 0;
   int   acks      = 0;

   player_bullet_if bus ();

   player_bullet dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic step();
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic act, input logic expl,
                          input logic ack, input logic [9:0] x, input logic [9:0] y);
      chk({tag, ".active"},  32'(bus.bullet_active),  32'(act));
      chk({tag, ".explode"}, 32'(bus.bullet_explode), 32'(expl));
      chk({tag, ".ack"},     32'(bus.fire_ack),       32'(ack));
      chk({tag, ".x"},       32'(bus.bullet_X),       32'(x));
      chk({tag, ".y"},       32'(bus.bullet_Y),       32'(y));
   endtask

   initial begin
      bus.shoot_bullet = 1'b0;
      bus.player_X     = '0;
      bus.bullet_hit   = 1'b0;
      step();
      step();
      chk_out("reset", 0, 0, 0, 10'd0, 10'd0);
      Reset_n = 1'b1;
      step();
      chk_out("idle", 0, 0, 0, 10'd0, 10'd0);

      // Launch and fly to the top; a re-fire and player moves mid-flight are ignored
      bus.player_X     = 10'd200;
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("launch", 1, 0, 1, 10'd200, 10'd440);
      bus.shoot_bullet = 1'b0;
      bus.player_X     = 10'd123;
      step();
      chk_out("step1", 1, 0, 0, 10'd200, 10'd436);
      for (int y = 432; y >= 0; y -= 4) begin
         bus.shoot_bullet = (y == 420);
         step();
         chk_out("fly", 1, 0, 0, 10'd200, 10'(y));
      end
      bus.shoot_bullet = 1'b0;
      step();
      chk_out("exit", 0, 0, 0, 10'd200, 10'd0);

      // Cooldown: drop at 5 frames in, accept at frame 16
      repeat (5) step();
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("cd_drop", 0, 0, 0, 10'd200, 10'd0);
      bus.shoot_bullet = 1'b0;
      repeat (10) step();
      bus.player_X     = 10'd300;
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("cd_accept", 1, 0, 1, 10'd300, 10'd440);
      bus.shoot_bullet = 1'b0;

      // Hit at Y=300, explosion held 8 frames with hit/fire ignored
      repeat (35) step();
      chk_out("pre_hit", 1, 0, 0, 10'd300, 10'd300);
      bus.bullet_hit = 1'b1;
      step();
      chk_out("hit", 0, 1, 0, 10'd300, 10'd300);
      bus.bullet_hit = 1'b0;
      for (int i = 1; i < 8; i++) begin
         bus.shoot_bullet = (i == 2);
         bus.bullet_hit   = (i == 3);
         step();
         chk_out("explode", 0, 1, 0, 10'd300, 10'd300);
      end
      bus.shoot_bullet = 1'b0;
      bus.bullet_hit   = 1'b0;
      step();
      chk_out("expl_end", 0, 0, 0, 10'd300, 10'd300);

      // Held request: one launch only
      repeat (16) step();
      bus.player_X     = 10'd500;
      bus.shoot_bullet = 1'b1;
      acks = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.fire_ack === 1'b1) acks++;
      end
      chk("held_acks", 32'(acks), 32'd1);
      chk_out("held_y", 1, 0, 0, 10'd500, 10'd44);
      bus.shoot_bullet = 1'b0;

      // Hit on the top-exit cycle explodes instead of exiting
      repeat (11) step();
      chk_out("top", 1, 0, 0, 10'd500, 10'd0);
      bus.bullet_hit = 1'b1;
      step();
      chk_out("top_hit", 0, 1, 0, 10'd500, 10'd0);
      bus.bullet_hit = 1'b0;
      repeat (7) step();
      chk_out("top_expl_last", 0, 1, 0, 10'd500, 10'd0);
      step();
      chk_out("top_idle", 0, 0, 0, 10'd500, 10'd0);

      // Re-press after release launches again
      repeat (16) step();
      bus.player_X     = 10'd77;
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("repress", 1, 0, 1, 10'd77, 10'd440);
      bus.shoot_bullet = 1'b0;
      step();
      chk_out("repress_fly", 1, 0, 0, 10'd77, 10'd436);

      // Reset mid-explosion with the request held through release
      bus.bullet_hit = 1'b1;
      step();
      chk_out("hit2", 0, 1, 0, 10'd77, 10'd436);
      bus.bullet_hit = 1'b0;
      step();
      step();
      Reset_n          = 1'b0;
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("rst_mid", 0, 0, 0, 10'd0, 10'd0);
      Reset_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.fire_ack === 1'b1) acks++;
      end
      chk("rst_held_acks", 32'(acks), 32'd0);
      chk_out("rst_held", 0, 0, 0, 10'd0, 10'd0);
      bus.shoot_bullet = 1'b0;
      step();
      bus.shoot_bullet = 1'b1;
      step();
      chk_out("rst_repress", 1, 0, 1, 10'd77, 10'd440);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
